sopc_irq_controller: RTL and testbench
======================================

Name: sopc_irq_controller

Overview:
- Avalon-MM interrupt aggregator that consumes the irq outputs of the SOPC timer peripherals and other slaves, and produces a single registered interrupt request to the Nios II CPU.
- Each source is individually configurable as level- or rising-edge-sensitive, maskable, software-forceable and acknowledgeable.
- Provides a lowest-index-first vector register so the ISR can find the active source with one read.
- Register map uses the same 3-bit address / 16-bit data slave style as the timers.

Parameters:
NUM_IRQ, 8, number of irq_in sources (1..16); register bits at and above NUM_IRQ read 0 and ignore writes.

Ports:
clk  input  1  system clock.
reset_n  input  1  reset; one clock; reset is synchronous and active-low.
address  input  3  register word address.
chipselect  input  1  slave select.
write_n  input  1  active-low write strobe, valid with chipselect.
writedata  input  16  write data.
irq_in  input  NUM_IRQ  interrupt requests from peripherals, synchronous to clk.
readdata  output  16  registered read data.
irq  output  1  registered interrupt request to CPU.

Behaviour:
- Reset (reset_n low at a clk edge): pending, enable, mode, prev_in, readdata and irq all 0. Reset mid-operation discards all pending state.
- Write strobe: wr(a) = chipselect & ~write_n & (address==a).
- Register map:
  - 0 STATUS, RO: pending & enable.
  - 1 PENDING, R / W1C: raw pending.
  - 2 ENABLE, RW: mask.
  - 3 MODE, RW: 1 = rising edge, 0 = level.
  - 4 VECTOR, RO. Write acknowledges the current vector.
  - 5 FORCE, WO: reads 0.
  - 6-7: read 0, writes ignored.
- Read latency: readdata <= mux(address) every clock regardless of chipselect, so data appears 1 cycle after address.
- prev_in <= irq_in every cycle, independent of mode.
- Level bit (mode=0):
  - pending[i] <= irq_in[i] (1-cycle registered copy).
  - W1C, FORCE and VECTOR-ack have no effect.
- Edge bit (mode=1):
  - set = (irq_in[i] & ~prev_in[i]) | (wr(5) & writedata[i]).
  - clr = (wr(1) & writedata[i]) | (wr(4) & vector_valid & vector_idx==i).
  - Set has priority over clr in the same cycle; otherwise hold.
  - Because prev_in resets to 0, an input already high at reset release registers one edge in the first cycle after reset.
- MODE write: any bit whose mode value changes has pending cleared that cycle. The new mode applies from the next cycle.
- Active vector is active = pending & enable.
  - vector_valid = |active.
  - vector_idx = lowest i with active[i].
  - VECTOR read value = {vector_valid, 11'b0, vector_idx[3:0]}; reads 0 when not valid.
  - The ack uses the vector computed from the current-cycle registers.
- irq <= |(pending & enable), registered.
  - Edge latency: input rising edge at cycle N -> pending at N+1 -> irq at N+2.
  - Deassert: a W1C at cycle M clears pending at M+1, and irq falls at M+2.
- ENABLE changes only gate STATUS, VECTOR and irq. Pending keeps accumulating while masked.
- Writes with chipselect low, or to addresses 6-7, have no effect.

Test Plan:
- Reset with irq_in=0 -> readdata=0, irq=0; ENABLE/MODE/PENDING read 0x0000.
- MODE=0x0001, ENABLE=0x0001; pulse irq_in[0] high for 1 cycle at N -> PENDING=0x0001, irq=1 from N+2. Write PENDING 0x0001 -> irq=0 two cycles later.
- Level source 3 (MODE=0, ENABLE=0x0008): hold irq_in[3] high -> irq stays 1, and a W1C write of 0x0008 does not clear it. Drop irq_in[3] -> irq=0 two cycles later.
- Edge sources 2 and 5 pending, ENABLE=0x0024 -> VECTOR reads 0x8002. Write VECTOR -> VECTOR reads 0x8005. Write again -> 0x0000 and irq falls.
- Edge source 1: irq_in[1] rising edge in the same cycle as a W1C of bit 1 -> PENDING bit 1 stays 1 (set wins). FORCE 0x0010 with MODE bit 4 = 0 -> no change.
- Edge source 6 pending while ENABLE=0 -> STATUS=0 and irq=0. Set ENABLE=0x0040 -> irq=1 two cycles after the write; then reset_n low mid-operation -> all state 0 next cycle.

Source files
------------

// File: rtl/sopc_irq_controller.sv
// Avalon-MM interrupt aggregator: per-source level/edge capture, masking,
// software force/acknowledge, lowest-index vector and a registered CPU irq.
module sopc_irq_controller #(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq
);

  typedef enum logic [2:0] {
    ADDR_STATUS  = 3'd0,
    ADDR_PENDING = 3'd1,
    ADDR_ENABLE  = 3'd2,
    ADDR_MODE    = 3'd3,
    ADDR_VECTOR  = 3'd4,
    ADDR_FORCE   = 3'd5
  } reg_addr_e;

  logic [NUM_IRQ-1:0] pending, enable, mode, prev_in;
  logic [NUM_IRQ-1:0] pending_next, active, wdata, mode_change, edge_set;
  logic               wr_en, wr_pending, wr_enable, wr_mode, wr_vector, wr_force;
  logic               vector_valid;
  logic [3:0]         vector_idx;
  logic [15:0]        read_mux;

  // Register bits at and above NUM_IRQ are never stored, so the upper data bits go unused.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  function automatic logic [15:0] widen(input logic [NUM_IRQ-1:0] v);
    widen = '0;
    widen[NUM_IRQ-1:0] = v;
  endfunction

  assign wdata      = writedata[NUM_IRQ-1:0];
  assign wr_en      = chipselect & ~write_n;
  assign wr_pending = wr_en && (address == ADDR_PENDING);
  assign wr_enable  = wr_en && (address == ADDR_ENABLE);
  assign wr_mode    = wr_en && (address == ADDR_MODE);
  assign wr_vector  = wr_en && (address == ADDR_VECTOR);
  assign wr_force   = wr_en && (address == ADDR_FORCE);

  assign active       = pending & enable;
  assign vector_valid = |active;
  assign mode_change  = wr_mode ? (wdata ^ mode) : '0;
  assign edge_set     = (irq_in & ~prev_in) | ({NUM_IRQ{wr_force}} & wdata);

  // Scanning downward leaves the lowest active index as the final assignment.
  always_comb begin
    vector_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) vector_idx = 4'(i);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pending_next = pending;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (mode_change[i]) begin
        pending_next[i] = 1'b0;
      end else if (!mode[i]) begin
        pending_next[i] = irq_in[i];
      end else if (edge_set[i]) begin
        pending_next[i] = 1'b1;
      end else if ((wr_pending && wdata[i]) ||
                   (wr_vector && vector_valid && (vector_idx == 4'(i)))) begin
        pending_next[i] = 1'b0;
      end
    end
  end

  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_STATUS:  read_mux = widen(active);
      ADDR_PENDING: read_mux = widen(pending);
      ADDR_ENABLE:  read_mux = widen(enable);
      ADDR_MODE:    read_mux = widen(mode);
      ADDR_VECTOR:  read_mux = {vector_valid, 11'b0, vector_idx};
      default:      read_mux = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending  <= '0;
      enable   <= '0;
      mode     <= '0;
      prev_in  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev_in  <= irq_in;
      pending  <= pending_next;
      readdata <= read_mux;
      irq      <= vector_valid;
      if (wr_enable) enable <= wdata;
      if (wr_mode)   mode   <= wdata;
    end
  end

endmodule

// File: tb/tb_sopc_irq_controller.sv
// Directed bench for sopc_irq_controller: register access, level/edge capture,
// vector acknowledge, masking and mid-operation reset.
module tb_sopc_irq_controller;

  localparam int NUM_IRQ = 8;

  logic               clk;
  logic               reset_n;
  logic [2:0]         address;
  logic               chipselect;
  logic               write_n;
  logic [15:0]        writedata;
  logic [NUM_IRQ-1:0] irq_in;
  logic [15:0]        readdata;
  logic               irq;

  int tests_run    = 0;
  int tests_failed = 0;

  sopc_irq_controller #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .irq_in     (irq_in),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {15'b0, irq}, {15'b0, exp});
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    irq_in     = '0;
    tick();
    tick();
    check("reset_readdata", readdata, 16'h0000);
    check_irq("reset_irq", 1'b0);
    reset_n = 1'b1;
    read_check("reset_enable", 3'd2, 16'h0000);
    read_check("reset_mode", 3'd3, 16'h0000);
    read_check("reset_pending", 3'd1, 16'h0000);

    // Edge source 0: pulse, two-cycle irq latency, W1C deassert.
    wr_reg(3'd3, 16'h0001);
    wr_reg(3'd2, 16'h0001);
    irq_in[0] = 1'b1;
    tick();
    irq_in[0] = 1'b0;
    check_irq("edge0_irq_n1", 1'b0);
    tick();
    check_irq("edge0_irq_n2", 1'b1);
    read_check("edge0_pending", 3'd1, 16'h0001);
    wr_reg(3'd1, 16'h0001);
    check_irq("edge0_w1c_m1", 1'b1);
    tick();
    check_irq("edge0_w1c_m2", 1'b0);

    // Level source 3: W1C has no effect, follows input.
    wr_reg(3'd3, 16'h0000);
    wr_reg(3'd2, 16'h0008);
    irq_in[3] = 1'b1;
    tick();
    tick();
    check_irq("lvl3_irq_on", 1'b1);
    wr_reg(3'd1, 16'h0008);
    tick();
    check_irq("lvl3_after_w1c", 1'b1);
    read_check("lvl3_pending", 3'd1, 16'h0008);
    irq_in[3] = 1'b0;
    tick();
    check_irq("lvl3_drop_m1", 1'b1);
    tick();
    check_irq("lvl3_drop_m2", 1'b0);

    // Edge sources 2 and 5: vector and acknowledge.
    wr_reg(3'd3, 16'h0024);
    wr_reg(3'd2, 16'h0024);
    irq_in = 8'h24;
    tick();
    irq_in = '0;
    tick();
    read_check("vec_first", 3'd4, 16'h8002);
    wr_reg(3'd4, 16'h0000);
    read_check("vec_second", 3'd4, 16'h8005);
    check_irq("vec_irq_held", 1'b1);
    wr_reg(3'd4, 16'h0000);
    check_irq("vec_ack2_m1", 1'b1);
    read_check("vec_empty", 3'd4, 16'h0000);
    check_irq("vec_irq_fall", 1'b0);

    // Edge source 1: set wins over same-cycle W1C.
    wr_reg(3'd3, 16'h0026);
    address    = 3'd1;
    writedata  = 16'h0002;
    chipselect = 1'b1;
    write_n    = 1'b0;
    irq_in[1]  = 1'b1;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    irq_in[1]  = 1'b0;
    read_check("set_wins", 3'd1, 16'h0002);
    wr_reg(3'd1, 16'h0002);
    read_check("edge1_w1c", 3'd1, 16'h0000);

    // FORCE: ignored on a level bit, sets an edge bit, reads 0.
    wr_reg(3'd5, 16'h0010);
    read_check("force_level", 3'd1, 16'h0000);
    wr_reg(3'd5, 16'h0020);
    read_check("force_edge", 3'd1, 16'h0020);
    read_check("force_read0", 3'd5, 16'h0000);
    wr_reg(3'd1, 16'h0020);
    read_check("force_clear", 3'd1, 16'h0000);

    // Edge source 6 pending while masked, then unmasked, then reset.
    wr_reg(3'd2, 16'h0000);
    wr_reg(3'd3, 16'h0066);
    irq_in[6] = 1'b1;
    tick();
    irq_in[6] = 1'b0;
    tick();
    read_check("masked_status", 3'd0, 16'h0000);
    check_irq("masked_irq", 1'b0);
    read_check("masked_pending", 3'd1, 16'h0040);
    wr_reg(3'd2, 16'h0040);
    check_irq("unmask_m1", 1'b0);
    tick();
    check_irq("unmask_m2", 1'b1);
    read_check("unmask_vector", 3'd4, 16'h8006);
    read_check("unmask_status", 3'd0, 16'h0040);
    reset_n = 1'b0;
    tick();
    check("midreset_readdata", readdata, 16'h0000);
    check_irq("midreset_irq", 1'b0);
    reset_n = 1'b1;
    read_check("midreset_pending", 3'd1, 16'h0000);
    read_check("midreset_enable", 3'd2, 16'h0000);
    read_check("midreset_mode", 3'd3, 16'h0000);

    // Unimplemented bits, reserved addresses, deselected writes.
    wr_reg(3'd2, 16'hFFFF);
    read_check("enable_width", 3'd2, 16'h00FF);
    wr_reg(3'd7, 16'hFFFF);
    read_check("addr7_read0", 3'd7, 16'h0000);
    address    = 3'd3;
    writedata  = 16'hFFFF;
    chipselect = 1'b0;
    write_n    = 1'b0;
    tick();
    write_n    = 1'b1;
    read_check("nocs_mode", 3'd3, 16'h0000);
    check_irq("final_irq", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
